// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: registered ALU control decoder that also sequences a
// multi-cycle multiply/divide unit (start pulse, upstream stall, done pulse).
// Optional feature macro: ALU_CTRL_FLUSH_EN adds flush_i, which aborts an
// in-flight MDU op and suppresses an accept in IDLE.
module alu_ctrl_mc #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [4:0]        funct_i,
`ifdef ALU_CTRL_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic              ready_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              ctrl_valid_o,
  output logic              illegal_o,
  output logic              mdu_start_o,
  output logic              stall_o,
  output logic              mdu_done_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]        dec_code;
  logic              dec_illegal;
  logic              dec_mdu;
  logic              dec_div;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              flush;
  logic              accept;

`ifdef ALU_CTRL_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Decode ALUOp/funct into a 4-bit code plus MDU classification.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    dec_code    = 4'b0010;
    dec_illegal = 1'b0;
    dec_mdu     = 1'b0;
    dec_div     = 1'b0;
    unique case (ALUOp_i)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b10: begin
        if (!funct_i[4]) begin
          case (funct_i[3:0])
            4'b0000: dec_code = 4'b0010;
            4'b1000: dec_code = 4'b0110;
            4'b0111: dec_code = 4'b0000;
            4'b0110: dec_code = 4'b0001;
            4'b0010: dec_code = 4'b0111;
            default: dec_illegal = 1'b1;
          endcase
        end else begin
          case (funct_i[2:0])
            3'b000: begin dec_code = 4'b1000; dec_mdu = 1'b1; end
            3'b001: begin dec_code = 4'b1001; dec_mdu = 1'b1; end
            3'b100: begin dec_code = 4'b1010; dec_mdu = 1'b1; dec_div = 1'b1; end
            3'b110: begin dec_code = 4'b1011; dec_mdu = 1'b1; dec_div = 1'b1; end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      2'b11: begin
        case (funct_i[2:0])
          3'b000:  dec_code = 4'b0010;
          3'b010:  dec_code = 4'b0111;
          3'b111:  dec_code = 4'b0000;
          3'b110:  dec_code = 4'b0001;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_ctrl = dec_illegal ? '1 : CTRL_W'(dec_code);
  assign accept   = valid_i & ready_o & ~flush;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an abort from flush overrides normal sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && dec_mdu) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
  end

  // State-derived outputs; ready is held low while reset is asserted.
  always_comb begin
    ready_o    = (state_q == IDLE) && !rst_i;
    stall_o    = (state_q == BUSY);
    mdu_done_o = (state_q == DONE);
  end

  // Registered control code, result pulses and the BUSY cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ALUCtrl_o    <= '0;
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      mdu_start_o  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ctrl_valid_o <= accept;
      illegal_o    <= accept & dec_illegal;
      mdu_start_o  <= accept & dec_mdu;
      if (accept) ALUCtrl_o <= dec_ctrl;
      if (accept && dec_mdu)
        cnt_q <= dec_div ? DIV_LOAD : MUL_LOAD;
      else if (state_q == BUSY && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Registered, multi-cycle successor to the single-cycle ALU control decoder.
- Decodes ALUOp/funct into a CTRL_W-bit ALU control code, including RV32M mul/div/rem.
- Sequences a multi-cycle multiply/divide unit: start pulse, stall of the upstream pipeline, done pulse.
- Sits between the main decoder/control and the ALU/MDU in the multi-cycle CPU.

Parameters:
- CTRL_W, 4, ALU control output width; must be >= 4; codes zero-extended, except invalid which is all-ones.
- MUL_LAT, 4, BUSY cycles for mul/mulh; must be >= 1.
- DIV_LAT, 32, BUSY cycles for div/rem; must be >= 1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  op request.
- ALUOp_i  in  2  00 ld/sd, 01 beq, 10 R-type, 11 I-type.
- funct_i  in  5  {funct7[0], funct7[5], funct3[2:0]}.
- ready_o  out  1  block can accept an op.
- ALUCtrl_o  out  CTRL_W  registered ALU control code, held until the next accept.
- ctrl_valid_o  out  1  one-cycle pulse: ALUCtrl_o newly updated.
- illegal_o  out  1  pulse with ctrl_valid_o when the decode is invalid.
- mdu_start_o  out  1  one-cycle MDU start pulse.
- stall_o  out  1  high while the MDU op is in flight.
- mdu_done_o  out  1  one-cycle pulse at MDU completion.

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state IDLE, counter 0, ALUCtrl_o=0, all pulse outputs 0, stall_o=0. ready_o=0 while rst_i=1.
- Decode:
  - ALUOp 00 -> add 0010.
  - ALUOp 01 -> sub 0110.
  - ALUOp 10 with funct[4]=0, by funct[3:0]: 0000 add 0010, 1000 sub 0110, 0111 and 0000, 0110 or 0001, 0010 slt 0111, others invalid.
  - ALUOp 10 with funct[4]=1, by funct[2:0]: 000 mul 1000, 001 mulh 1001, 100 div 1010, 110 rem 1011, others invalid.
  - ALUOp 11, by funct[2:0] (funct[4:3] ignored): 000 add, 010 slt, 111 and, 110 or, others invalid.
  - Invalid -> ALUCtrl_o all-ones, illegal_o=1.
- FSM states: IDLE, BUSY, DONE.
  - ready_o=1 only in IDLE. Accept = valid_i & ready_o, sampled at the edge.
  - IDLE, accept of a non-MDU or invalid op: next cycle ALUCtrl_o updated and ctrl_valid_o=1; stay IDLE. Back-to-back accepts give one result per cycle.
  - IDLE, accept of an MDU op: next cycle ALUCtrl_o updated, ctrl_valid_o=1, mdu_start_o=1, stall_o=1; go BUSY with cnt=LAT-1.
  - BUSY: stall_o=1. Each edge: if cnt==0 go DONE, else cnt--. BUSY therefore lasts exactly LAT cycles.
  - DONE: one cycle; mdu_done_o=1, stall_o=0, ready_o=0; then IDLE.
  - Total occupancy of an MDU op: LAT+1 cycles after the accept edge.
- Counter width: clog2(max(MUL_LAT, DIV_LAT)) bits, minimum 1. No wrap is possible.
- valid_i while not ready_o: ignored, not queued; the requester holds it.
- rst_i at any time, including mid-BUSY: next state IDLE, no mdu_done_o, outputs return to reset values.

Optional Feature:
- Macro: ALU_CTRL_FLUSH_EN.
- Defined:
  - Adds input flush_i (1 bit).
  - flush_i=1 in BUSY or DONE: next state IDLE, stall_o=0, no mdu_done_o. ALUCtrl_o keeps its value.
  - flush_i=1 in IDLE: suppresses accept that cycle; no ctrl_valid_o.
  - Reset has priority over flush.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset, then ALUOp=10, funct=01000, valid 1 cycle -> next cycle ALUCtrl_o=0110, ctrl_valid_o=1, illegal_o=0, ready_o stays 1.
- ALUOp=11, funct=xx010, then ALUOp=00 on the consecutive cycle -> ALUCtrl_o=0111 then 0010, ctrl_valid_o high 2 cycles.
- ALUOp=10, funct=10000 (mul), MUL_LAT=4 -> mdu_start_o at cycle 1, stall_o cycles 1-4, mdu_done_o at cycle 5, ready_o=1 at cycle 6; valid_i held during busy is not accepted until cycle 6.
- ALUOp=10, funct=10100 (div), DIV_LAT=32, rst_i asserted at BUSY cycle 10 -> next cycle stall_o=0, ALUCtrl_o=0, no mdu_done_o ever.
- ALUOp=10, funct=00101 -> ALUCtrl_o=1111 (all-ones for CTRL_W=6: 111111), illegal_o=1 one cycle.
- With ALU_CTRL_FLUSH_EN: rem op, flush_i at BUSY cycle 2 -> IDLE next cycle, stall_o=0, no mdu_done_o, a new op is accepted immediately.
